t07_pixel_scanner: RTL and testbench

- Raster sequencer directly upstream of the circle/cross pixel generators and downstream of game logic.
- On a start request it walks every pixel of the 320x240 frame and drives x/y to the generators.
- It captures their registered hit flags one cycle later and resolves each pixel to an RGB565 colour.
- It streams the colour to the display driver over a valid/ready handshake, then pulses frame_done.

---
 rtl/t07_pixel_pkg.sv | 9 +
 rtl/t07_pixel_scanner_if.sv | 8 +
 rtl/t07_raster_counter.sv | 39 +++
 rtl/t07_pixel_scanner.sv | 77 +++++++
 tb/tb_t07_pixel_scanner.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/t07_pixel_pkg.sv
// t07_pixel_pkg: scanner states, grid geometry constants and border colour.
package t07_pixel_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    typedef enum logic {ISSUE, CAPTURE} phase_t;
    localparam int          GRID_ORIGIN  = 12;
    localparam int          CELL_PITCH   = 36;
    localparam int          GRID_END     = 228;
    localparam logic [15:0] BORDER_COLOR = 16'hFFFF;
endpackage

// File: rtl/t07_pixel_scanner_if.sv
// t07_pixel_scanner_if: valid/ready RGB565 pixel stream from scanner to display driver.
interface t07_pixel_scanner_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    modport master (output pix_data, pix_valid, input pix_ready);
    modport slave  (input pix_data, pix_valid, output pix_ready);
endinterface

// File: rtl/t07_raster_counter.sv
// t07_raster_counter: raster-order x/y counters with clear, enable and last-pixel flag.
module t07_raster_counter #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [8:0] x_o,
    output logic [7:0] y_o,
    output logic       last_o
);
    localparam logic [8:0] X_LAST = 9'(H_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       eol, adv;
    // next coordinate: clear restarts at origin, advance never moves past the final pixel
    always_comb begin
        eol = x_q == X_LAST;
        adv = en_i && !(eol && y_q == Y_LAST);
        x_d = clr_i ? '0 : adv ? (eol ? '0 : x_q + 9'd1) : x_q;
        y_d = clr_i ? '0 : (adv && eol) ? y_q + 8'd1 : y_q;
    end
    // coordinate registers, cleared to origin on reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_q == X_LAST && y_q == Y_LAST;
endmodule

// File: rtl/t07_pixel_scanner.sv
// t07_pixel_scanner: frame raster sequencer resolving generator hits to RGB565 (border option: T07_BORDER_EN).
module t07_pixel_scanner
    import t07_pixel_pkg::*;
#(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int GEN_LAT = 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    output logic [8:0]                 x,
    output logic [7:0]                 y,
    input  logic                       circlePixel,
    input  logic                       crossPixel,
    input  logic [15:0]                bg_color,
    input  logic [15:0]                circle_color,
    input  logic [15:0]                cross_color,
    t07_pixel_scanner_if.master        pix,
    output logic                       busy,
    output logic                       frame_done
);
    if (GEN_LAT != 1) begin : g_lat_chk
        $error("t07_pixel_scanner supports only GEN_LAT == 1");
    end
    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [15:0] data_q, data_d, color;
    logic        valid_q, valid_d, done_q, done_d;
    logic        clr, load, xfer, last;
    t07_raster_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr_i  (clr),
        .en_i   (load),
        .x_o    (x),
        .y_o    (y),
        .last_o (last)
    );
    // scan sequencing, capture/handshake and colour priority
    always_comb begin
        xfer  = valid_q && pix.pix_ready;
        load  = state_q == SCAN && phase_q == CAPTURE && (!valid_q || pix.pix_ready);
        clr   = state_q == IDLE && start;
`ifdef T07_BORDER_EN
        color = (int'(x) < GRID_ORIGIN || int'(x) >= GRID_END || int'(y) < GRID_ORIGIN || int'(y) >= GRID_END) ? BORDER_COLOR :
                circlePixel ? circle_color : crossPixel ? cross_color : bg_color;
`else
        color = circlePixel ? circle_color : crossPixel ? cross_color : bg_color;
`endif
        state_d = clr ? SCAN : (load && last) ? DRAIN : (state_q == DRAIN && xfer) ? IDLE : state_q;
        phase_d = state_q != SCAN ? ISSUE : phase_q == ISSUE ? CAPTURE : load ? ISSUE : CAPTURE;
        data_d  = load ? color : data_q;
        valid_d = load || (valid_q && !xfer);
        done_d  = state_q == DRAIN && xfer;
    end
    // state, phase and output registers; reset abandons any partial frame
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            phase_q <= ISSUE;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
    assign pix.pix_data  = data_q;
    assign pix.pix_valid = valid_q;
    assign busy          = state_q != IDLE;
    assign frame_done    = done_q;
endmodule

// File: tb/tb_t07_pixel_scanner.sv
// tb_t07_pixel_scanner: randomized frame scans checked against a pixel-map reference and scoreboard.
module tb_t07_pixel_scanner;
    localparam int H = 48;
    localparam int V = 128;
    localparam int N = H * V;
    logic        clk, nrst, start, pix_ready, busy, frame_done, circ_q, cross_q;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] bg, circ_c, cross_c;
    bit          cmap [N];
    bit          xmap [N];
    bit          mode;
    int          checks, errors, xfers, fd_cnt;
    int          prev_x, prev_y, nx, ny, px, py;
    logic        prev_busy, prev_valid, prev_ready, prev_nrst;
    logic [15:0] prev_data;
    t07_pixel_scanner_if pif();
    assign pif.pix_ready = pix_ready;
    t07_pixel_scanner #(.H_RES(H), .V_RES(V)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .x            (x),
        .y            (y),
        .circlePixel  (circ_q),
        .crossPixel   (cross_q),
        .bg_color     (bg),
        .circle_color (circ_c),
        .cross_color  (cross_c),
        .pix          (pif.master),
        .busy         (busy),
        .frame_done   (frame_done)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) begin
        circ_q  <= cmap[int'(y) * H + int'(x)];
        cross_q <= xmap[int'(y) * H + int'(x)];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [15:0] ref_col(input int cx, input int cy);
`ifdef T07_BORDER_EN
        if (cx < 12 || cx >= 228 || cy < 12 || cy >= 228) return 16'hFFFF;
`endif
        if (cmap[cy * H + cx]) return circ_c;
        if (xmap[cy * H + cx]) return cross_c;
        return bg;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_xfers(input int n, input int lim);
        int c = 0;
        while (xfers < n && c < lim) begin
            tick;
            c++;
        end
        chk("wait_xfers", 32'(xfers >= n), 1);
    endtask
    task automatic wait_done(input int lim);
        int c = 0;
        while (!frame_done && c < lim) begin
            tick;
            c++;
        end
        chk("done_seen", 32'(frame_done), 1);
    endtask
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = mode ? ($urandom_range(99) >= 30) : 1'b1;
        end
    end
    always @(negedge clk) begin
        if (nrst && prev_nrst) begin
            if (busy && !prev_busy) begin
                xfers  = 0;
                fd_cnt = 0;
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", 32'(pif.pix_valid), 1);
                chk("stall_data", 32'(pif.pix_data), 32'(prev_data));
            end
            if (busy && prev_busy && (int'(x) != prev_x || int'(y) != prev_y)) begin
                nx = prev_x == H - 1 ? 0 : prev_x + 1;
                ny = prev_x == H - 1 ? prev_y + 1 : prev_y;
                chk("next_x", 32'(x), 32'(nx));
                chk("next_y", 32'(y), 32'(ny));
            end
            if (pif.pix_valid && pix_ready) begin
                if (xfers >= N) chk("extra_xfer", 32'(xfers), 32'(N - 1));
                else begin
                    px = xfers % H;
                    py = xfers / H;
                    chk("pix", 32'(pif.pix_data), 32'(ref_col(px, py)));
                    if (px == 26 && py == 123 && circ_c == 16'hF800) chk("pix_26_123", 32'(pif.pix_data), 32'hF800);
`ifdef T07_BORDER_EN
                    if (px == 5 && py == 100) chk("pix_5_100", 32'(pif.pix_data), 32'hFFFF);
`endif
                end
                xfers++;
            end
            if (frame_done) fd_cnt++;
        end
        prev_nrst  = nrst;
        prev_busy  = busy;
        prev_valid = pif.pix_valid;
        prev_ready = pix_ready;
        prev_data  = pif.pix_data;
        prev_x     = int'(x);
        prev_y     = int'(y);
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        checks = 0; errors = 0; xfers = 0; fd_cnt = 0;
        prev_nrst = 0; prev_busy = 0; prev_valid = 0; prev_ready = 0; prev_data = 0;
        nrst = 0; start = 0; mode = 0;
        bg = 16'h0000; circ_c = 16'hF800; cross_c = 16'h001F;
        for (int i = 0; i < N; i++) begin
            cmap[i] = $urandom_range(3) == 0;
            xmap[i] = $urandom_range(2) == 0;
        end
        cmap[123 * H + 26] = 1;
        xmap[123 * H + 26] = 1;
        repeat (2) tick;
        chk("rst_valid", 32'(pif.pix_valid), 0);
        chk("rst_data", 32'(pif.pix_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        nrst = 1;
        tick;
        start = 1;
        tick;
        start = 0;
        chk("busy_start", 32'(busy), 1);
        tick;
        wait_xfers(1000, 4000);
        start = 1;
        tick;
        start = 0;
        wait_done(20000);
        chk("xfers_A", 32'(xfers), 32'(N));
        chk("busy_at_done", 32'(busy), 0);
        tick;
        chk("busy_after", 32'(busy), 0);
        chk("fd_one_cycle", 32'(frame_done), 0);
        repeat (5) tick;
        chk("fd_cnt_A", 32'(fd_cnt), 1);
        chk("start_ignored", 32'(busy), 0);
        bg = 16'($urandom); circ_c = 16'($urandom); cross_c = 16'($urandom);
        mode = 1;
        start = 1;
        tick;
        chk("busy_B", 32'(busy), 1);
        wait_done(40000);
        chk("xfers_B", 32'(xfers), 32'(N));
        chk("busy_at_done_B", 32'(busy), 0);
        tick;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_x", 32'(x), 0);
        chk("restart_y", 32'(y), 0);
        start = 0;
        tick;
        wait_xfers(500, 3000);
        nrst = 0;
        tick;
        chk("mrst_valid", 32'(pif.pix_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_x", 32'(x), 0);
        chk("mrst_y", 32'(y), 0);
        chk("mrst_done", 32'(frame_done), 0);
        nrst = 1;
        repeat (20) tick;
        chk("mrst_no_fd", 32'(fd_cnt), 0);
        chk("mrst_idle", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
